// File: rtl/vx_dcache_rsp_arb.sv
// Round-robin merge of NUM_INPUTS dcache response channels into one registered
// response channel; the winner index is appended to the tag. Optional stall
// counter enabled by defining VX_DCACHE_RSP_ARB_PERF_EN.
module vx_dcache_rsp_arb #(
  parameter  int NUM_INPUTS    = 2,
  parameter  int NUM_REQS      = 4,
  parameter  int WORD_SIZE     = 4,
  parameter  int TAG_IN_WIDTH  = 8,
  localparam int WORD_WIDTH    = 8 * WORD_SIZE,
  localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_INPUTS-1:0]                    rsp_in_valid,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]           rsp_in_tmask,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_WIDTH-1:0] rsp_in_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]       rsp_in_tag,
  output logic [NUM_INPUTS-1:0]                    rsp_in_ready,
  output logic                                     rsp_out_valid,
  output logic [NUM_REQS-1:0]                      rsp_out_tmask,
  output logic [NUM_REQS*WORD_WIDTH-1:0]           rsp_out_data,
  output logic [TAG_OUT_WIDTH-1:0]                 rsp_out_tag,
  input  logic                                     rsp_out_ready
`ifdef VX_DCACHE_RSP_ARB_PERF_EN
  ,
  output logic [31:0]                              perf_stall_cycles
`endif
);

  localparam int PTR_W  = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int DATA_W = NUM_REQS * WORD_WIDTH;

  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         win;
  logic [PTR_W-1:0]         ptr_next;
  logic                     found;
  logic [NUM_INPUTS-1:0]    grant;
  logic                     stage_en;
  logic                     accept;
  logic [NUM_REQS-1:0]      win_tmask;
  logic [DATA_W-1:0]        win_data;
  logic [TAG_IN_WIDTH-1:0]  win_tag;
  logic [TAG_OUT_WIDTH-1:0] tag_next;

  // Search starts at ptr and wraps; the first valid input found wins.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!found && rsp_in_valid[(int'(ptr) + k) % NUM_INPUTS]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr) + k) % NUM_INPUTS);
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign stage_en     = !rsp_out_valid || rsp_out_ready;
  assign accept       = !reset && stage_en && found;
  assign rsp_in_ready = {NUM_INPUTS{!reset && stage_en}} & grant;
  assign ptr_next     = (win == PTR_W'(NUM_INPUTS - 1)) ? '0 : win + 1'b1;

  assign win_tmask = rsp_in_tmask[win * NUM_REQS +: NUM_REQS];
  assign win_data  = rsp_in_data[win * DATA_W +: DATA_W];
  assign win_tag   = rsp_in_tag[win * TAG_IN_WIDTH +: TAG_IN_WIDTH];

  generate
    if (SEL_BITS > 0) begin : g_sel
      assign tag_next = {win_tag, win[SEL_BITS-1:0]};
    end else begin : g_nosel
      assign tag_next = win_tag;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_out_valid <= 1'b0;
      ptr           <= '0;
    end else if (stage_en) begin
      rsp_out_valid <= found;
      if (found) ptr <= ptr_next;
    end
  end

  // NOTE: payload registers are deliberately not reset; they are qualified by
  // rsp_out_valid, and leaving them unreset keeps the wide datapath cheap.
  always_ff @(posedge clk) begin
    if (accept) begin
      rsp_out_tmask <= win_tmask;
      rsp_out_data  <= win_data;
      rsp_out_tag   <= tag_next;
    end
  end

`ifdef VX_DCACHE_RSP_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else if (rsp_out_valid && !rsp_out_ready && (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_dcache_rsp_arb.sv
// Self-checking bench for vx_dcache_rsp_arb with four inputs: directed vector
// table, hand-written stall sequence, and randomized run against a queue-free model.
module tb_vx_dcache_rsp_arb;

  localparam int N    = 4;
  localparam int R    = 4;
  localparam int TW   = 8;
  localparam int DW   = R * 32;
  localparam int TOW  = TW + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     rsp_in_valid;
  logic [N*R-1:0]   rsp_in_tmask;
  logic [N*DW-1:0]  rsp_in_data;
  logic [N*TW-1:0]  rsp_in_tag;
  logic [N-1:0]     rsp_in_ready;
  logic             rsp_out_valid;
  logic [R-1:0]     rsp_out_tmask;
  logic [DW-1:0]    rsp_out_data;
  logic [TOW-1:0]   rsp_out_tag;
  logic             rsp_out_ready;
`ifdef VX_DCACHE_RSP_ARB_PERF_EN
  logic [31:0]      perf_stall_cycles;
`endif

  logic [R-1:0]  tm_in [N];
  logic [DW-1:0] d_in  [N];
  logic [TW-1:0] tg_in [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rsp_in_tmask[g*R +: R]   = tm_in[g];
    assign rsp_in_data[g*DW +: DW]  = d_in[g];
    assign rsp_in_tag[g*TW +: TW]   = tg_in[g];
  end

  vx_dcache_rsp_arb #(
    .NUM_INPUTS(N), .NUM_REQS(R), .WORD_SIZE(4), .TAG_IN_WIDTH(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rsp_in_valid(rsp_in_valid),
    .rsp_in_tmask(rsp_in_tmask),
    .rsp_in_data(rsp_in_data),
    .rsp_in_tag(rsp_in_tag),
    .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid),
    .rsp_out_tmask(rsp_out_tmask),
    .rsp_out_data(rsp_out_data),
    .rsp_out_tag(rsp_out_tag),
    .rsp_out_ready(rsp_out_ready)
`ifdef VX_DCACHE_RSP_ARB_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] vld;
    logic         ordy;
    logic [N-1:0] rdy;   // expected rsp_in_ready during the cycle
    logic         ov;    // expected rsp_out_valid after the edge
    logic [TOW-1:0] tag; // expected rsp_out_tag after the edge (when ov)
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [N-1:0] vld, logic ordy,
                              logic [N-1:0] rdy, logic ov, logic [TOW-1:0] tag);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.tag = tag;
    return v;
  endfunction

  // Behavioural reference state for the random run.
  logic          m_v;
  logic [R-1:0]  m_tm;
  logic [DW-1:0] m_d;
  logic [TOW-1:0] m_tag;
  int            m_ptr;

  task automatic rand_cycle(input logic rst);
    int  w;
    bit  hit;
    bit  en;
    logic [N-1:0] exp_rdy;
    reset         = rst;
    rsp_in_valid  = N'($urandom);
    rsp_out_ready = ($urandom_range(3) != 0);
    for (int i = 0; i < N; i++) begin
      tm_in[i] = R'($urandom);
      d_in[i]  = {$urandom, $urandom, $urandom, $urandom};
      tg_in[i] = TW'($urandom);
    end
    en  = !m_v || rsp_out_ready;
    hit = 1'b0;
    w   = 0;
    for (int k = 0; k < N; k++) begin
      if (!hit && rsp_in_valid[(m_ptr + k) % N]) begin
        hit = 1'b1;
        w   = (m_ptr + k) % N;
      end
    end
    exp_rdy = (!rst && en && hit) ? N'(1 << w) : '0;
    @(negedge clk);
    check("rand_ready", DW'(rsp_in_ready), DW'(exp_rdy));
    if (rst) begin
      m_v = 1'b0; m_ptr = 0;
    end else if (en) begin
      m_v = hit;
      if (hit) begin
        m_tm  = tm_in[w];
        m_d   = d_in[w];
        m_tag = {tg_in[w], 2'(w)};
        m_ptr = (w + 1) % N;
      end
    end
    @(posedge clk); #1;
    check("rand_valid", DW'(rsp_out_valid), DW'(m_v));
    if (m_v) begin
      check("rand_tmask", DW'(rsp_out_tmask), DW'(m_tm));
      check("rand_data", rsp_out_data, m_d);
      check("rand_tag", DW'(rsp_out_tag), DW'(m_tag));
    end
  endtask

  initial begin
    logic [DW-1:0]  hold_d;
    logic [R-1:0]   hold_tm;
    logic [TOW-1:0] hold_tag;

    reset = 1'b1; rsp_in_valid = '0; rsp_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tm_in[i] = R'(i + 1);
      d_in[i]  = {4{32'hA0 + 32'(i)}};
      tg_in[i] = TW'(8'h10 + i);
    end

    // tag out = {0x10+i, i[1:0]}: 0x040, 0x045, 0x04A, 0x04F
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 10'h000));
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 10'h000));
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 10'h000));
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 10'h040));
    tbl.push_back(mk(0, 4'hF, 1, 4'h2, 1, 10'h045));
    tbl.push_back(mk(0, 4'hF, 1, 4'h4, 1, 10'h04A));
    tbl.push_back(mk(0, 4'hF, 1, 4'h8, 1, 10'h04F));
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 10'h040));
    tbl.push_back(mk(0, 4'h8, 1, 4'h8, 1, 10'h04F));  // ptr wraps to 0
    tbl.push_back(mk(0, 4'h2, 1, 4'h2, 1, 10'h045));  // ptr -> 2
    tbl.push_back(mk(0, 4'h3, 1, 4'h1, 1, 10'h040));  // search 2,3,0
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 0, 10'h000));  // bubble, ptr holds 1
    tbl.push_back(mk(0, 4'h5, 1, 4'h4, 1, 10'h04A));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 10'h04A));  // stalled: hold
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 10'h04A));
    tbl.push_back(mk(0, 4'hF, 1, 4'h8, 1, 10'h04F));  // consume + accept together
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 10'h04F));
    tbl.push_back(mk(1, 4'hF, 0, 4'h0, 0, 10'h000));  // reset while full
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 10'h040));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; rsp_in_valid = tbl[i].vld; rsp_out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), DW'(rsp_in_ready), DW'(tbl[i].rdy));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), DW'(rsp_out_valid), DW'(tbl[i].ov));
      if (tbl[i].ov) check($sformatf("tbl%0d_tag", i), DW'(rsp_out_tag), DW'(tbl[i].tag));
    end

    // Backpressure: payload must stay frozen while inputs churn.
    reset = 1'b1; rsp_in_valid = '0; rsp_out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rsp_in_valid = 4'h4;
    d_in[2] = {$urandom, $urandom, $urandom, $urandom}; tm_in[2] = 4'h0;
    hold_d = d_in[2]; hold_tm = tm_in[2]; hold_tag = {tg_in[2], 2'd2};
    @(posedge clk); #1;
    check("bp_first_valid", DW'(rsp_out_valid), DW'(1'b1));
    check("bp_zero_tmask", DW'(rsp_out_tmask), DW'(hold_tm));
    rsp_out_ready = 1'b0; rsp_in_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) d_in[i] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_ready_low", DW'(rsp_in_ready), DW'(0));
      @(posedge clk); #1;
      check("bp_data_hold", rsp_out_data, hold_d);
      check("bp_tag_hold", DW'(rsp_out_tag), DW'(hold_tag));
      check("bp_valid_hold", DW'(rsp_out_valid), DW'(1'b1));
    end
    rsp_out_ready = 1'b1;
    hold_d = d_in[3];
    @(negedge clk);
    check("bp_resume_ready", DW'(rsp_in_ready), DW'(4'h8));
    @(posedge clk); #1;
    check("bp_resume_tag", DW'(rsp_out_tag), DW'({tg_in[3], 2'd3}));
    check("bp_resume_data", rsp_out_data, hold_d);

    // Randomized run against the reference model (starts from a reset).
    m_v = 1'b0; m_ptr = 0; m_tm = '0; m_d = '0; m_tag = '0;
    rand_cycle(1'b1);
    for (int c = 0; c < 400; c++) rand_cycle($urandom_range(63) == 0);

`ifdef VX_DCACHE_RSP_ARB_PERF_EN
    reset = 1'b1; rsp_in_valid = '0; rsp_out_ready = 1'b0;
    @(posedge clk); #1;
    check("perf_reset", DW'(perf_stall_cycles), DW'(0));
    reset = 1'b0; rsp_in_valid = 4'h1;
    @(posedge clk); #1;
    rsp_in_valid = '0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
    end
    check("perf_stall7", DW'(perf_stall_cycles), DW'(7));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vx_dcache_rsp_arb.md
Name: vx_dcache_rsp_arb

Overview:
- Round-robin arbiter that merges NUM_INPUTS independent dcache response channels (valid/tmask/data/tag/ready) into one response channel of the same shape.
- Sits between the per-bank/per-port dcache response sources and the core LSU response port.
- Appends the winning input index to the outgoing tag so the consumer can route the response.
- Output is fully registered: one pipeline stage, no combinational valid/data path from input to output.

Parameters:
- NUM_INPUTS, 2, number of response sources; legal 1..16
- NUM_REQS, 4, lanes per response
- WORD_SIZE, 4, bytes per lane word; WORD_WIDTH = 8*WORD_SIZE
- TAG_IN_WIDTH, 8, tag width per input
- SEL_BITS, derived: clog2(NUM_INPUTS) if NUM_INPUTS>1, else 0
- TAG_OUT_WIDTH, derived: TAG_IN_WIDTH + SEL_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rsp_in_valid  in  NUM_INPUTS  per-input response valid
- rsp_in_tmask  in  NUM_INPUTS*NUM_REQS  per-input lane mask
- rsp_in_data  in  NUM_INPUTS*NUM_REQS*WORD_WIDTH  per-input lane data
- rsp_in_tag  in  NUM_INPUTS*TAG_IN_WIDTH  per-input tag
- rsp_in_ready  out  NUM_INPUTS  per-input accept
- rsp_out_valid  out  1  merged response valid
- rsp_out_tmask  out  NUM_REQS  merged lane mask
- rsp_out_data  out  NUM_REQS*WORD_WIDTH  merged data
- rsp_out_tag  out  TAG_OUT_WIDTH  {input tag, winner index}; index in the low SEL_BITS bits
- rsp_out_ready  in  1  consumer accept

Behaviour:
- Clock, reset: single clock clk. Reset is synchronous and active-high on port reset.
- Handshakes:
  - Input transfer occurs when rsp_in_valid[i] && rsp_in_ready[i].
  - Output transfer occurs when rsp_out_valid && rsp_out_ready.
- Stage enable: stage_en = !rsp_out_valid || rsp_out_ready.
- Grant:
  - Combinational round-robin over rsp_in_valid, starting at priority pointer ptr.
  - Winner w is the first valid input at index ptr, ptr+1, … modulo NUM_INPUTS.
- rsp_in_ready[i] = stage_en && grant[i]. At most one bit is set per cycle. Ready never asserts for an input whose valid is low.
- On an input transfer, the next edge does the following:
  - The output register loads tmask/data of w.
  - rsp_out_tag loads {tag_w, w[SEL_BITS-1:0]}.
  - rsp_out_valid goes to 1.
  - ptr loads (w+1) mod NUM_INPUTS.
- No input transfer but stage_en: rsp_out_valid goes to 0; ptr holds.
- !stage_en: the output register and ptr hold; all payload is stable while valid && !ready.
- Latency and throughput: 1 cycle from input accept to rsp_out_valid. Throughput is 1 response/cycle when rsp_out_ready is held high.
- Fairness: any continuously valid input is granted within NUM_INPUTS consecutive output transfers.
- Payload rules:
  - tmask == 0 responses are forwarded unmodified; no filtering.
  - Payload is not inspected.
- NUM_INPUTS == 1: no index bits; the tag passes unchanged; ptr is constant 0; the block degenerates to a one-entry pipeline register.
- Reset values: rsp_out_valid = 0; ptr = 0; rsp_in_ready = 0 during reset. tmask/data/tag registers are don't-care, but the bench must not check them while valid = 0.
- Reset mid-operation: a held response is dropped; next cycle valid = 0 and ptr = 0. Inputs are not accepted in the reset cycle.
- Simultaneous events:
  - Accept and output consume happen in the same cycle.
  - The new response replaces the old one with no bubble.
- ptr wrap: when w = NUM_INPUTS-1, ptr goes to 0. ptr width is max(SEL_BITS,1).

Optional Feature:
- Macro: VX_DCACHE_RSP_ARB_PERF_EN.
- Defined: adds output port perf_stall_cycles, 32 bits.
  - Increments each cycle where rsp_out_valid && !rsp_out_ready.
  - Saturates at 0xFFFFFFFF.
  - Synchronous reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset for 3 cycles with all inputs valid -> rsp_out_valid = 0 and all rsp_in_ready = 0 throughout; first grant after release goes to input 0.
- Round-robin throughput: NUM_INPUTS = 4, all inputs valid continuously, rsp_out_ready = 1, tags 0x10..0x13 -> output tag low bits go 0,1,2,3,0,…, one response per cycle, upper tag matches the source.
- Backpressure: hold rsp_out_ready = 0 for 5 cycles after the first output -> tmask/data/tag are stable, rsp_in_ready is all 0, the input holding its valid is not lost, and the order resumes when ready returns.
- Sparse and wrap: only input 3 valid, then only input 1 -> grants are 3 then 1; ptr wraps to 0 after 3, then goes to 2 after 1.
- Reset while full: output valid and stalled, pulse reset for 1 cycle -> valid = 0 next cycle and the first post-reset grant obeys ptr = 0.
- Perf (macro defined): stall the output for 7 cycles -> perf_stall_cycles = 7; preload near the maximum -> the counter holds at 0xFFFFFFFF.
